// File: rtl/apb_slave_ws.sv
// Parametrised APB slave memory with programmable wait states, byte-lane
// write strobes and an error response for addresses beyond DEPTH.
module apb_slave_ws #(
  parameter int AWIDTH      = 8,
  parameter int DWIDTH      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_sel,
  input  logic                  p_en,
  input  logic                  p_write,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [DWIDTH-1:0]     wdata,
  input  logic [DWIDTH/8-1:0]   p_strb,
  output logic [DWIDTH-1:0]     rdata,
  output logic                  p_ready,
  output logic                  p_slverr
);

  localparam int NLANE = DWIDTH / 8;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH + 1)'(DEPTH);
  localparam logic [3:0]      WS_L    = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 err_q;
  logic                 write_q;
  logic [AWIDTH-1:0]    addr_q;
  logic [DWIDTH-1:0]    wdata_q;
  logic [NLANE-1:0]     strb_q;
  logic [DWIDTH-1:0]    mem [DEPTH];

  function automatic logic out_of_range(input logic [AWIDTH-1:0] a);
    return ({1'b0, a} >= DEPTH_L);
  endfunction

  function automatic logic [DWIDTH-1:0] merge_lanes(input logic [DWIDTH-1:0] old_w,
                                                    input logic [DWIDTH-1:0] new_w,
                                                    input logic [NLANE-1:0]  strb);
    logic [DWIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NLANE; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  logic          err_now;
  logic [IW-1:0] idx_now;
  logic [IW-1:0] idx_q;

  assign err_now = out_of_range(addr);
  assign idx_now = addr[IW-1:0];
  assign idx_q   = addr_q[IW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      rdata    <= '0;
      p_ready  <= 1'b0;
      p_slverr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Only a proper setup phase (sel without enable) starts a transfer.
          if (p_sel && !p_en) begin
            addr_q  <= addr;
            write_q <= p_write;
            wdata_q <= wdata;
            strb_q  <= p_strb;
            err_q   <= err_now;
            cnt     <= WS_L;
            state   <= ACCESS;
            if (WAIT_STATES == 0) begin
              p_ready  <= 1'b1;
              p_slverr <= err_now;
              if (!p_write) rdata <= err_now ? '0 : mem[idx_now];
            end
          end
        end
        ACCESS: begin
          if (!p_sel) begin
            p_ready  <= 1'b0;
            p_slverr <= 1'b0;
            state    <= IDLE;
          end else if (!p_ready) begin
            if (p_en) begin
              cnt <= cnt - 4'd1;
              if (cnt == 4'd1) begin
                p_ready  <= 1'b1;
                p_slverr <= err_q;
                if (!write_q) rdata <= err_q ? '0 : mem[idx_q];
              end
            end
          end else if (p_en) begin
            // Completion edge: the write commits here and nowhere else.
            if (write_q && !err_q) mem[idx_q] <= merge_lanes(mem[idx_q], wdata_q, strb_q);
            p_ready  <= 1'b0;
            p_slverr <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_ws.sv
// Scoreboard bench for apb_slave_ws: three instances with 0, 3 and 2 wait
// states, driven by directed and random transfers against a memory model.
module tb_apb_slave_ws;

  localparam int ND = 3;

  typedef struct {
    int          d;
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst     [ND];
  logic        p_sel   [ND];
  logic        p_en    [ND];
  logic        p_write [ND];
  logic [7:0]  addr    [ND];
  logic [31:0] wdata   [ND];
  logic [3:0]  p_strb  [ND];
  logic [31:0] rdata   [ND];
  logic        p_ready [ND];
  logic        p_slverr[ND];

  logic [31:0] model [ND][64];
  exp_t        sbq[$];
  int          vectors = 0;
  int          fails   = 0;

  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  function automatic logic [31:0] apply_strobes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  st);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, d, act, exp);
    end
  endtask

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb_slave_ws #(
      .AWIDTH(8), .DWIDTH(32), .DEPTH(64),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) dut (
      .clk(clk), .rst(rst[g]), .p_sel(p_sel[g]), .p_en(p_en[g]),
      .p_write(p_write[g]), .addr(addr[g]), .wdata(wdata[g]), .p_strb(p_strb[g]),
      .rdata(rdata[g]), .p_ready(p_ready[g]), .p_slverr(p_slverr[g])
    );

    int   wc = 0;
    exp_t e;

    // Monitor: counts access cycles with p_ready low, checks on completion.
    always @(negedge clk) begin
      if (p_slverr[g] === 1'b1 && p_ready[g] !== 1'b1) begin
        fails++;
        $display("FAIL slverr_without_ready dut%0d: p_slverr=%b p_ready=%b", g, p_slverr[g], p_ready[g]);
      end
      if (rst[g] || !p_sel[g] || !p_en[g]) begin
        wc = 0;
      end else if (p_ready[g] !== 1'b1) begin
        wc++;
      end else begin
        if (sbq.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_ready dut%0d: got completion, expected none", g);
        end else begin
          e = sbq.pop_front();
          chk("owner", g, 32'(g), 32'(e.d));
          chk("wait_cycles", g, 32'(wc), 32'(e.waits));
          chk("slverr", g, 32'(p_slverr[g]), 32'(e.err));
          if (e.rd) chk("rdata", g, rdata[g], e.data);
        end
        wc = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] st);
    exp_t e;
    logic err;
    int   n;
    err     = (a >= 8'd64);
    e.d     = d;
    e.rd    = !wr;
    e.err   = err;
    e.data  = err ? 32'h0 : model[d][a[5:0]];
    e.waits = ws_of(d);
    sbq.push_back(e);
    p_sel[d] = 1'b1; p_en[d] = 1'b0; p_write[d] = wr;
    addr[d] = a; wdata[d] = wd; p_strb[d] = st;
    @(posedge clk); #1;
    // Scramble the bus during access; the slave must use its latched copy.
    p_en[d] = 1'b1;
    addr[d] = 8'($urandom); wdata[d] = $urandom; p_strb[d] = 4'($urandom);
    n = 0;
    @(negedge clk);
    while (p_ready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (p_ready[d] !== 1'b1) begin
      vectors++;
      fails++;
      $display("FAIL timeout dut%0d: p_ready=%b, expected 1 within 20 cycles", d, p_ready[d]);
    end
    @(posedge clk); #1;
    p_sel[d] = 1'b0; p_en[d] = 1'b0;
    if (wr && !err && n < 20) model[d][a[5:0]] = apply_strobes(model[d][a[5:0]], wd, st);
  endtask

  task automatic abort_write(input int d, input logic [7:0] a, input logic [31:0] wd);
    p_sel[d] = 1'b1; p_en[d] = 1'b0; p_write[d] = 1'b1;
    addr[d] = a; wdata[d] = wd; p_strb[d] = 4'hF;
    @(posedge clk); #1;
    p_en[d] = 1'b1;
    @(posedge clk); #1;
    p_sel[d] = 1'b0; p_en[d] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ready_low", d, 32'(p_ready[d]), 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic no_setup(input int d);
    p_sel[d] = 1'b1; p_en[d] = 1'b1; p_write[d] = 1'b0; addr[d] = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("no_setup_ready_low", d, 32'(p_ready[d]), 32'h0);
    @(posedge clk); #1;
    p_sel[d] = 1'b0; p_en[d] = 1'b0;
  endtask

  task automatic reset_mid(input int d, input logic [7:0] a);
    p_sel[d] = 1'b1; p_en[d] = 1'b0; p_write[d] = 1'b1;
    addr[d] = a; wdata[d] = 32'hFEEDFACE; p_strb[d] = 4'hF;
    @(posedge clk); #1;
    p_en[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0; p_sel[d] = 1'b0; p_en[d] = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", d, 32'(p_ready[d]), 32'h0);
    chk("rst_mid_slverr", d, 32'(p_slverr[d]), 32'h0);
    chk("rst_mid_rdata", d, rdata[d], 32'h0);
    for (int i = 0; i < 64; i++) model[d][i] = 32'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] a;
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; p_sel[d] = 1'b0; p_en[d] = 1'b0; p_write[d] = 1'b0;
      addr[d] = 8'h0; wdata[d] = 32'h0; p_strb[d] = 4'h0;
      for (int i = 0; i < 64; i++) model[d][i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("reset_ready", d, 32'(p_ready[d]), 32'h0);
      chk("reset_slverr", d, 32'(p_slverr[d]), 32'h0);
      chk("reset_rdata", d, rdata[d], 32'h0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;
    idle(1);

    // Zero wait states: basic read/write, strobes, errors, back-to-back.
    xfer(0, 1'b0, 8'h05, 32'h0, 4'h0);
    xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 8'h10, 32'h0, 4'h0);
    xfer(0, 1'b1, 8'h03, 32'hAABBCCDD, 4'hF);
    xfer(0, 1'b1, 8'h03, 32'h11223344, 4'b0101);
    xfer(0, 1'b0, 8'h03, 32'h0, 4'h0);
    xfer(0, 1'b1, 8'h00, 32'h0BADF00D, 4'hF);
    xfer(0, 1'b1, 8'h40, 32'h12345678, 4'hF);
    xfer(0, 1'b0, 8'h40, 32'h0, 4'h0);
    xfer(0, 1'b0, 8'h00, 32'h0, 4'h0);
    xfer(0, 1'b1, 8'hFF, 32'hCAFEBABE, 4'hF);
    xfer(0, 1'b0, 8'hFF, 32'h0, 4'h0);
    xfer(0, 1'b0, 8'h3F, 32'h0, 4'h0);
    no_setup(0);

    // Three wait states, then reset in the middle of a write.
    xfer(1, 1'b1, 8'h01, 32'h0000CAFE, 4'hF);
    xfer(1, 1'b0, 8'h01, 32'h0, 4'h0);
    xfer(1, 1'b1, 8'h20, 32'h76543210, 4'hF);
    reset_mid(1, 8'h01);
    for (int i = 0; i < 64; i++) xfer(1, 1'b0, 8'(i), 32'h0, 4'h0);

    // Two wait states: abort, protocol violation, reset mid-transfer.
    xfer(2, 1'b1, 8'h02, 32'h5A5A5A5A, 4'hF);
    abort_write(2, 8'h02, 32'hFFFFFFFF);
    xfer(2, 1'b0, 8'h02, 32'h0, 4'h0);
    no_setup(2);
    xfer(2, 1'b0, 8'h02, 32'h0, 4'h0);
    reset_mid(2, 8'h02);
    xfer(2, 1'b0, 8'h02, 32'h0, 4'h0);

    // Random traffic on each instance.
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 9) == 0)      a = 8'hFF;
        else if ($urandom_range(0, 1) == 1) a = 8'($urandom_range(0, 7));
        else                                a = 8'($urandom_range(0, 71));
        xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
        idle($urandom_range(0, 2));
      end
    end

    idle(3);
    chk("scoreboard_drained", 0, 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
